// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Moves single-word stores and 1..4 beat burst loads between a core-side
// request/response handshake and a simple data memory with asynchronous read.
// Only one operation is in flight at a time. New requests are taken only in
// IDLE, and nothing is queued.
//
// Ports
//   clk, rst         single clock; asynchronous active-high reset
//   req_valid/ready  request handshake (ready only in IDLE)
//   req_we           1 = store, 0 = load
//   req_addr         start address
//   req_wdata        store data
//   req_len          load beats minus one (ignored for stores)
//   resp_valid/ready load beat handshake
//   resp_rdata       load beat data, held stable while stalled
//   mem_write_en     one-cycle write strobe to the data memory
//   mem_addr         current address register
//   mem_write_data   latched store data
//   mem_read_data    asynchronous read data from the data memory
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_len,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q,   state_d;
    logic [ADDR_W-1:0] curAddr_q, curAddr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic              we_q,      we_d;
    logic [1:0]        beatCnt_q, beatCnt_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;

    // State and datapath registers. Reset is asynchronous so an operation in
    // progress is abandoned the moment rst rises, without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            curAddr_q <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            beatCnt_q <= 2'd0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            curAddr_q <= curAddr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            beatCnt_q <= beatCnt_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state logic. Every register holds by default. IDLE latches the
    // whole request. READ samples the memory on its way out, so a beat is
    // presented in RESP one cycle later. Each RESP handshake either finishes
    // the burst or steps the address and the beat counter.
    always_comb begin
        state_d   = state_q;
        curAddr_d = curAddr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        beatCnt_d = beatCnt_q;
        rdata_d   = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    curAddr_d = req_addr;
                    wdata_d   = req_wdata;
                    we_d      = req_we;
                    beatCnt_d = req_len;
                    state_d   = req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            READ: begin
                rdata_d = mem_read_data;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    if (beatCnt_q == 2'd0) begin
                        state_d = IDLE;
                    end else begin
                        beatCnt_d = beatCnt_q - 2'd1;
                        curAddr_d = curAddr_q + ADDR_ONE;
                        state_d   = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode directly from the state and the registers. The write
    // strobe is also qualified by the latched direction, so a load can never
    // reach the memory write port.
    always_comb begin
        req_ready      = (state_q == IDLE);
        resp_valid     = (state_q == RESP);
        mem_write_en   = (state_q == WRITE) && we_q;
        mem_addr       = curAddr_q;
        mem_write_data = wdata_q;
        resp_rdata     = rdata_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit. A small behavioural data memory sits on
// the memory port. Each scenario task drives its own stimulus and compares
// outputs on the falling edge against hand-computed values.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic [1:0] req_len;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_rdata;
    logic       mem_write_en;
    logic [3:0] mem_addr;
    logic [7:0] mem_write_data;
    logic [7:0] mem_read_data;

    logic [7:0] mem [16];
    logic       tbMemWe;
    logic [3:0] tbMemAddr;
    logic [7:0] tbMemData;

    int checkCount;
    int passCount;

    load_store_unit #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_len        (req_len),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .mem_write_en   (mem_write_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural data memory: DUT write port, plus a bench-side preload port
    always @(posedge clk) begin
        if (mem_write_en)
            mem[mem_addr] <= mem_write_data;
        else if (tbMemWe)
            mem[tbMemAddr] <= tbMemData;
    end

    assign mem_read_data = mem[mem_addr];

    // Preload one memory word through the bench port
    task automatic loadMemory(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        tbMemWe   = 1'b1;
        tbMemAddr = a;
        tbMemData = d;
        @(negedge clk);
        tbMemWe   = 1'b0;
    endtask

    // Offer one request for a single cycle; returns at the falling edge of the
    // first cycle after acceptance
    task automatic applyStimulus(input logic we, input logic [3:0] a,
                                 input logic [7:0] d, input logic [1:0] len);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_len   = len;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Reset values while rst is held, including with a request offered
    task automatic test_reset;
        @(negedge clk);
        checkCount++;
        if ({req_ready, resp_valid, mem_write_en} !== 3'b100)
            $display("[TB] FAIL reset_flags got=%b want=100", {req_ready, resp_valid, mem_write_en});
        else passCount++;
        checkCount++;
        if (resp_rdata !== 8'h00) $display("[TB] FAIL reset_rdata got=%h want=00", resp_rdata);
        else passCount++;
        checkCount++;
        if ({mem_addr, mem_write_data} !== 12'h000)
            $display("[TB] FAIL reset_addr_wdata got=%h want=000", {mem_addr, mem_write_data});
        else passCount++;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'd9;
        req_wdata = 8'hEE;
        @(negedge clk);
        @(negedge clk);
        checkCount++;
        if ({req_ready, mem_write_en, mem_addr} !== {1'b1, 1'b0, 4'd0})
            $display("[TB] FAIL reset_ignores_req got=%b want=100000", {req_ready, mem_write_en, mem_addr});
        else passCount++;
        req_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
    endtask

    // Store addr 3 / 0xA5, then load it back
    task automatic test_store;
        resp_ready = 1'b1;
        applyStimulus(1'b1, 4'd3, 8'hA5, 2'd2);
        checkCount++;
        if ({mem_write_en, mem_addr, mem_write_data} !== {1'b1, 4'd3, 8'hA5})
            $display("[TB] FAIL store_write got=%h want=%h", {mem_write_en, mem_addr, mem_write_data}, {1'b1, 4'd3, 8'hA5});
        else passCount++;
        checkCount++;
        if ({req_ready, resp_valid} !== 2'b00)
            $display("[TB] FAIL store_busy got=%b want=00", {req_ready, resp_valid});
        else passCount++;
        @(negedge clk);
        checkCount++;
        if ({req_ready, resp_valid, mem_write_en} !== 3'b100)
            $display("[TB] FAIL store_done got=%b want=100", {req_ready, resp_valid, mem_write_en});
        else passCount++;
        applyStimulus(1'b0, 4'd3, 8'h00, 2'd0);
        @(negedge clk);
        checkCount++;
        if ({resp_valid, resp_rdata} !== {1'b1, 8'hA5})
            $display("[TB] FAIL store_readback got=%h want=1a5", {resp_valid, resp_rdata});
        else passCount++;
        @(negedge clk);
        checkCount++;
        if ({req_ready, resp_valid} !== 2'b10)
            $display("[TB] FAIL store_readback_idle got=%b want=10", {req_ready, resp_valid});
        else passCount++;
    endtask

    // Single-beat load of addr 5 with two-cycle latency
    task automatic test_load_single;
        resp_ready = 1'b1;
        applyStimulus(1'b0, 4'd5, 8'h00, 2'd0);
        checkCount++;
        if ({req_ready, resp_valid, mem_write_en, mem_addr} !== {3'b000, 4'd5})
            $display("[TB] FAIL load_read_cycle got=%b want=0000101", {req_ready, resp_valid, mem_write_en, mem_addr});
        else passCount++;
        @(negedge clk);
        checkCount++;
        if ({resp_valid, resp_rdata} !== {1'b1, 8'h3C})
            $display("[TB] FAIL load_beat got=%h want=13c", {resp_valid, resp_rdata});
        else passCount++;
        @(negedge clk);
        checkCount++;
        if ({req_ready, resp_valid} !== 2'b10)
            $display("[TB] FAIL load_idle got=%b want=10", {req_ready, resp_valid});
        else passCount++;
    endtask

    // Four-beat burst from addr 14 wrapping through 15 -> 0 -> 1
    task automatic test_burst_wrap;
        logic [7:0] expData [4];
        logic [3:0] expAddr [4];
        expData = '{8'h11, 8'h22, 8'h33, 8'h44};
        expAddr = '{4'd14, 4'd15, 4'd0, 4'd1};
        resp_ready = 1'b1;
        applyStimulus(1'b0, 4'd14, 8'h00, 2'd3);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checkCount++;
            if ({resp_valid, mem_write_en, mem_addr} !== {2'b00, expAddr[i]})
                $display("[TB] FAIL burst_read%0d got=%b want=%b", i, {resp_valid, mem_write_en, mem_addr}, {2'b00, expAddr[i]});
            else passCount++;
            @(negedge clk);
            checkCount++;
            if ({resp_valid, resp_rdata} !== {1'b1, expData[i]})
                $display("[TB] FAIL burst_beat%0d got=%h want=%h", i, {resp_valid, resp_rdata}, {1'b1, expData[i]});
            else passCount++;
        end
        @(negedge clk);
        checkCount++;
        if ({req_ready, resp_valid} !== 2'b10)
            $display("[TB] FAIL burst_idle got=%b want=10", {req_ready, resp_valid});
        else passCount++;
    endtask

    // Two-beat burst with a five-cycle stall on beat 0
    task automatic test_stall;
        resp_ready = 1'b0;
        applyStimulus(1'b0, 4'd5, 8'h00, 2'd1);
        @(negedge clk);
        checkCount++;
        if ({resp_valid, resp_rdata} !== {1'b1, 8'h3C})
            $display("[TB] FAIL stall_beat0 got=%h want=13c", {resp_valid, resp_rdata});
        else passCount++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkCount++;
            if ({resp_valid, mem_write_en, resp_rdata, mem_addr} !== {2'b10, 8'h3C, 4'd5})
                $display("[TB] FAIL stall_hold%0d got=%h want=%h", i, {resp_valid, mem_write_en, resp_rdata, mem_addr}, {2'b10, 8'h3C, 4'd5});
            else passCount++;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checkCount++;
        if ({resp_valid, mem_addr} !== {1'b0, 4'd6})
            $display("[TB] FAIL stall_read1 got=%b want=00110", {resp_valid, mem_addr});
        else passCount++;
        @(negedge clk);
        checkCount++;
        if ({resp_valid, resp_rdata} !== {1'b1, 8'h5A})
            $display("[TB] FAIL stall_beat1 got=%h want=15a", {resp_valid, resp_rdata});
        else passCount++;
        @(negedge clk);
        checkCount++;
        if ({req_ready, resp_valid, mem_write_en} !== 3'b100)
            $display("[TB] FAIL stall_no_extra got=%b want=100", {req_ready, resp_valid, mem_write_en});
        else passCount++;
    endtask

    // Store request held during a burst is taken only once IDLE returns
    task automatic test_back_to_back;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd14;
        req_len   = 2'd1;
        @(negedge clk);
        req_we    = 1'b1;
        req_addr  = 4'd9;
        req_wdata = 8'hFF;
        req_len   = 2'd3;
        for (int i = 0; i < 4; i++) begin
            checkCount++;
            if ({req_ready, mem_write_en} !== 2'b00)
                $display("[TB] FAIL b2b_blocked%0d got=%b want=00", i, {req_ready, mem_write_en});
            else passCount++;
            @(negedge clk);
        end
        checkCount++;
        if ({req_ready, resp_valid} !== 2'b10)
            $display("[TB] FAIL b2b_idle got=%b want=10", {req_ready, resp_valid});
        else passCount++;
        @(negedge clk);
        req_valid = 1'b0;
        checkCount++;
        if ({mem_write_en, mem_addr, mem_write_data} !== {1'b1, 4'd9, 8'hFF})
            $display("[TB] FAIL b2b_store got=%h want=%h", {mem_write_en, mem_addr, mem_write_data}, {1'b1, 4'd9, 8'hFF});
        else passCount++;
        @(negedge clk);
    endtask

    // Reset pulsed during beat 1 of a 4-beat load, then during a store
    task automatic test_reset_mid_op;
        resp_ready = 1'b1;
        applyStimulus(1'b0, 4'd14, 8'h00, 2'd3);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkCount++;
        if ({resp_valid, resp_rdata} !== {1'b1, 8'h22})
            $display("[TB] FAIL rstmid_beat1 got=%h want=122", {resp_valid, resp_rdata});
        else passCount++;
        #1 rst = 1'b1;
        #1;
        checkCount++;
        if ({req_ready, resp_valid, mem_write_en, resp_rdata, mem_addr} !== {3'b100, 8'h00, 4'd0})
            $display("[TB] FAIL rstmid_async got=%h want=%h", {req_ready, resp_valid, mem_write_en, resp_rdata, mem_addr}, {3'b100, 8'h00, 4'd0});
        else passCount++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkCount++;
            if ({req_ready, resp_valid, mem_write_en} !== 3'b100)
                $display("[TB] FAIL rstmid_quiet%0d got=%b want=100", i, {req_ready, resp_valid, mem_write_en});
            else passCount++;
        end
        applyStimulus(1'b1, 4'd7, 8'h77, 2'd0);
        checkCount++;
        if (mem_write_en !== 1'b1) $display("[TB] FAIL rstwr_strobe got=%b want=1", mem_write_en);
        else passCount++;
        #1 rst = 1'b1;
        #1;
        checkCount++;
        if ({req_ready, mem_write_en, mem_write_data} !== {2'b10, 8'h00})
            $display("[TB] FAIL rstwr_async got=%h want=200", {req_ready, mem_write_en, mem_write_data});
        else passCount++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkCount++;
        if (mem[7] !== 8'h00) $display("[TB] FAIL rstwr_no_write got=%h want=00", mem[7]);
        else passCount++;
        checkCount++;
        if ({req_ready, mem_write_en} !== 2'b10)
            $display("[TB] FAIL rstwr_idle got=%b want=10", {req_ready, mem_write_en});
        else passCount++;
    endtask

    // Scenario sequence; memory preload happens while reset is held
    initial begin
        checkCount = 0;
        passCount  = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 4'd0;
        req_wdata  = 8'h00;
        req_len    = 2'd0;
        resp_ready = 1'b0;
        tbMemWe    = 1'b0;
        tbMemAddr  = 4'd0;
        tbMemData  = 8'h00;
        loadMemory(4'd0,  8'h33);
        loadMemory(4'd1,  8'h44);
        loadMemory(4'd5,  8'h3C);
        loadMemory(4'd6,  8'h5A);
        loadMemory(4'd7,  8'h00);
        loadMemory(4'd14, 8'h11);
        loadMemory(4'd15, 8'h22);
        test_reset();
        test_store();
        test_load_single();
        test_burst_wrap();
        test_stall();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width (16 words).
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  request offered by the core.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  ADDR_W  start address.
REQ-009 req_wdata  input  DATA_W  store data.
REQ-010 req_len  input  2  load beats minus one (0..3 means 1..4 beats); ignored for stores.
REQ-011 resp_valid  output  1  load data beat available.
REQ-012 resp_ready  input  1  core accepts the load beat.
REQ-013 resp_rdata  output  DATA_W  load data beat.
REQ-014 mem_write_en  output  1  write enable to the data memory.
REQ-015 mem_addr  output  ADDR_W  data memory address.
REQ-016 mem_write_data  output  DATA_W  data memory write data.
REQ-017 mem_read_data  input  DATA_W  data memory asynchronous read data.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, READ and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-020 On acceptance, the unit SHALL latch addr, wdata, we and len into internal registers.
REQ-021 Transitions: IDLE->WRITE on an accepted store; IDLE->READ on an accepted load; WRITE->IDLE unconditionally.
REQ-022 Further transitions: READ->RESP unconditionally; RESP->READ on resp_ready=1 with beats remaining; RESP->IDLE on resp_ready=1 at the last beat; RESP holds while resp_ready=0.
REQ-023 mem_addr SHALL always equal the current-address register, and mem_write_data SHALL always equal the latched wdata.
REQ-024 mem_write_en SHALL be 1 only in WRITE, for exactly one cycle per accepted store.
REQ-025 In READ, resp_rdata SHALL capture mem_read_data at the clock edge leaving READ.
REQ-026 resp_valid SHALL be 1 exactly in RESP, and resp_rdata SHALL stay stable while resp_valid=1 and resp_ready=0.
REQ-027 Load latency: accept at edge N, READ in cycle N+1, resp_valid=1 in cycle N+2.
REQ-028 Sustained burst throughput SHALL be one beat per 2 cycles when resp_ready=1.
REQ-029 Store latency: mem_write_en=1 in the cycle after acceptance; req_ready returns 1 the cycle after that; stores produce no response.
REQ-030 The beat counter SHALL load len on acceptance and decrement on each RESP handshake; the last beat is when the counter equals 0.
REQ-031 The address SHALL increment by 1 on each non-last RESP handshake, modulo 2^ADDR_W (15 wraps to 0).
REQ-032 req_valid, req_* and req_len SHALL be ignored outside IDLE; no queuing.
REQ-033 The unit SHALL never assert mem_write_en during a load.

Reset
REQ-034 While rst=1, state SHALL be IDLE regardless of clk, and req_ready SHALL be 1.
REQ-035 While rst=1, resp_valid, mem_write_en and resp_rdata SHALL be 0, and the address, wdata and counter registers SHALL be 0.
REQ-036 Reset asserted mid-burst or mid-write SHALL abandon the operation immediately; no further writes or beats occur, and the unit restarts in IDLE after reset release.

Verification
REQ-037 Store addr=3, wdata=0xA5 -> mem_write_en=1 for exactly one cycle with mem_addr=3 and mem_write_data=0xA5; a subsequent load of addr 3 returns 0xA5.
REQ-038 Load addr=5, len=0, resp_ready=1, mem[5]=0x3C -> resp_valid=1 two cycles after acceptance with resp_rdata=0x3C, then IDLE.
REQ-039 Burst load addr=14, len=3, mem[14,15,0,1]=0x11,0x22,0x33,0x44 -> beats 0x11,0x22,0x33,0x44 in order (address wraps 15->0).
REQ-040 Burst len=1 with resp_ready held 0 for 5 cycles on beat 0 -> resp_valid and resp_rdata held stable, no extra beat, mem_write_en stays 0.
REQ-041 req_valid held 1 with new requests during a burst -> those requests are not accepted until req_ready=1 in IDLE.
REQ-042 rst pulsed during RESP of beat 1 of a 4-beat load -> outputs cleared asynchronously, req_ready=1 after release, and no remaining beats are issued.
